// File: rtl/misao_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module      : misao_boot_loader
//  Description : Holds the core in reset while a byte stream is copied into
//                memory starting at BASE_ADDR, then releases the core and
//                hands it the memory port as a transparent pass-through.
//  Revision    : 1.0 - initial release
// ============================================================================
module misao_boot_loader #(
  parameter logic [14:0] BASE_ADDR = 15'h0001,
  parameter int          LOAD_LEN  = 256
) (
  input  logic        clk,
  input  logic        rst,
  // load control and byte stream
  input  logic        ld_start,
  input  logic        ld_abort,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  output logic        ld_ready,
  output logic        cpu_rst,
  output logic        ld_done,
  // core-side memory port
  input  logic        cpu_mem_enable_read,
  input  logic        cpu_mem_enable_write,
  input  logic [14:0] cpu_mem_addr,
  input  logic [7:0]  cpu_mem_data_out,
  output logic [7:0]  cpu_mem_data_in,
  // memory-side port
  output logic        mem_enable_read,
  output logic        mem_enable_write,
  output logic [14:0] mem_addr,
  output logic [7:0]  mem_data_out,
  input  logic [7:0]  mem_data_in
);

  // Count of the final byte of a load; LOAD_LEN of 32768 maps to 15'h7FFF.
  localparam logic [14:0] c_LAST = 15'(LOAD_LEN - 1);

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_LOAD    = 2'd1,
    S_RELEASE = 2'd2,
    S_RUN     = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [14:0] r_count;
  logic [14:0] w_count_nxt;

  // State and byte-counter registers; reset parks the loader in HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_HOLD;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Next-state and output decode; while rst is high every output stays at its safe default.
  always_comb begin
    w_state_nxt      = r_state;
    w_count_nxt      = r_count;
    cpu_rst          = 1'b1;
    ld_ready         = 1'b0;
    ld_done          = 1'b0;
    mem_enable_read  = 1'b0;
    mem_enable_write = 1'b0;
    mem_addr         = '0;
    mem_data_out     = '0;
    cpu_mem_data_in  = '0;

    if (!rst) begin
      case (r_state)
        S_HOLD: begin
          if (ld_start) begin
            w_state_nxt = S_LOAD;
            w_count_nxt = '0;
          end
        end

        S_LOAD: begin
          ld_ready = 1'b1;
          // Abort wins over a handshake in the same cycle: nothing is written.
          if (ld_abort) begin
            w_state_nxt = S_HOLD;
            w_count_nxt = '0;
          end else if (ld_valid) begin
            mem_enable_write = 1'b1;
            mem_addr         = BASE_ADDR + r_count;  // 15-bit sum wraps naturally
            mem_data_out     = ld_data;
            if (r_count == c_LAST) begin
              w_state_nxt = S_RELEASE;
              w_count_nxt = '0;
            end else begin
              w_count_nxt = r_count + 15'd1;
            end
          end
        end

        S_RELEASE: begin
          ld_done     = 1'b1;
          w_count_nxt = '0;
          w_state_nxt = ld_start ? S_LOAD : S_RUN;
        end

        S_RUN: begin
          // Core owns the memory; a new load request still lets this cycle's access through.
          cpu_rst          = 1'b0;
          mem_enable_read  = cpu_mem_enable_read;
          mem_enable_write = cpu_mem_enable_write;
          mem_addr         = cpu_mem_addr;
          mem_data_out     = cpu_mem_data_out;
          cpu_mem_data_in  = mem_data_in;
          if (ld_start) begin
            w_state_nxt = S_LOAD;
            w_count_nxt = '0;
          end
        end

        default: begin
          w_state_nxt = S_HOLD;
          w_count_nxt = '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_misao_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_misao_boot_loader
//  Description : Self-checking bench for misao_boot_loader. Two instances
//                (base 1 and base 7FFE, four-byte loads) share one stimulus
//                stream and are compared against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_misao_boot_loader;

  localparam int          c_LEN    = 4;
  localparam logic [14:0] c_BASE_A = 15'h0001;
  localparam logic [14:0] c_BASE_B = 15'h7FFE;

  logic        clk = 1'b0;
  logic        t_rst, t_start, t_abort, t_valid;
  logic [7:0]  t_data;
  logic        t_cre, t_cwe;
  logic [14:0] t_caddr;
  logic [7:0]  t_cdo;

  logic        a_ready, a_cpu_rst, a_done, a_re, a_we;
  logic [7:0]  a_cdi, a_do, a_din;
  logic [14:0] a_addr;
  logic        b_ready, b_cpu_rst, b_done, b_re, b_we;
  logic [7:0]  b_cdi, b_do, b_din;
  logic [14:0] b_addr;

  // memories attached to each instance, and the model's view of them
  logic [7:0] mem_a [0:32767];
  logic [7:0] mem_b [0:32767];
  logic [7:0] ref_a [0:32767];
  logic [7:0] ref_b [0:32767];

  // model of the loader: which phase it is in and bytes accepted so far
  bit m_load, m_rel, m_run;
  int m_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  misao_boot_loader #(.BASE_ADDR(c_BASE_A), .LOAD_LEN(c_LEN)) u_a (
    .clk(clk), .rst(t_rst), .ld_start(t_start), .ld_abort(t_abort),
    .ld_valid(t_valid), .ld_data(t_data), .ld_ready(a_ready),
    .cpu_rst(a_cpu_rst), .ld_done(a_done),
    .cpu_mem_enable_read(t_cre), .cpu_mem_enable_write(t_cwe),
    .cpu_mem_addr(t_caddr), .cpu_mem_data_out(t_cdo), .cpu_mem_data_in(a_cdi),
    .mem_enable_read(a_re), .mem_enable_write(a_we), .mem_addr(a_addr),
    .mem_data_out(a_do), .mem_data_in(a_din)
  );

  misao_boot_loader #(.BASE_ADDR(c_BASE_B), .LOAD_LEN(c_LEN)) u_b (
    .clk(clk), .rst(t_rst), .ld_start(t_start), .ld_abort(t_abort),
    .ld_valid(t_valid), .ld_data(t_data), .ld_ready(b_ready),
    .cpu_rst(b_cpu_rst), .ld_done(b_done),
    .cpu_mem_enable_read(t_cre), .cpu_mem_enable_write(t_cwe),
    .cpu_mem_addr(t_caddr), .cpu_mem_data_out(t_cdo), .cpu_mem_data_in(b_cdi),
    .mem_enable_read(b_re), .mem_enable_write(b_we), .mem_addr(b_addr),
    .mem_data_out(b_do), .mem_data_in(b_din)
  );

  assign a_din = mem_a[a_addr];
  assign b_din = mem_b[b_addr];

  // simple synchronous-write memories behind each instance
  always @(posedge clk) begin
    if (a_we) mem_a[a_addr] <= a_do;
    if (b_we) mem_b[b_addr] <= b_do;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
  endtask

  // Expected outputs of one instance for the inputs currently applied.
  task automatic check_side(input string nm, input logic [14:0] base,
                            input logic g_cpu_rst, input logic g_ready, input logic g_done,
                            input logic g_we, input logic g_re, input logic [14:0] g_addr,
                            input logic [7:0] g_do, input logic [7:0] g_cdi,
                            input logic [7:0] exp_cdi);
    logic e_cpu_rst, e_ready, e_done, e_we, e_re;
    bool_hold: begin end
    e_cpu_rst = 1'b1; e_ready = 1'b0; e_done = 1'b0; e_we = 1'b0; e_re = 1'b0;
    if (!t_rst) begin
      if (m_load) begin
        e_ready = 1'b1;
        e_we    = t_valid && !t_abort;
      end else if (m_rel) begin
        e_done = 1'b1;
      end else if (m_run) begin
        e_cpu_rst = 1'b0;
        e_we      = t_cwe;
        e_re      = t_cre;
      end
    end
    check_val({nm, " cpu_rst"}, 32'(g_cpu_rst), 32'(e_cpu_rst));
    check_val({nm, " ld_ready"}, 32'(g_ready), 32'(e_ready));
    check_val({nm, " ld_done"}, 32'(g_done), 32'(e_done));
    check_val({nm, " mem_we"}, 32'(g_we), 32'(e_we));
    check_val({nm, " mem_re"}, 32'(g_re), 32'(e_re));
    if (!t_rst) begin
      check_val({nm, " cpu_mem_data_in"}, 32'(g_cdi), 32'(m_run ? exp_cdi : 8'h00));
      if (m_load && e_we) begin
        check_val({nm, " load addr"}, 32'(g_addr), 32'(15'((32'(base) + m_cnt) % 32768)));
        check_val({nm, " load data"}, 32'(g_do), 32'(t_data));
      end else if (m_run) begin
        check_val({nm, " run addr"}, 32'(g_addr), 32'(t_caddr));
        check_val({nm, " run data"}, 32'(g_do), 32'(t_cdo));
      end else if (!m_load && !m_rel) begin
        check_val({nm, " hold addr"}, 32'(g_addr), 32'd0);
        check_val({nm, " hold data"}, 32'(g_do), 32'd0);
      end
    end
  endtask

  // Apply one cycle of stimulus, check both instances, then advance the model.
  task automatic step(input logic r, input logic s, input logic ab, input logic v,
                      input logic [7:0] d, input logic cre, input logic cwe,
                      input logic [14:0] ca, input logic [7:0] cdo);
    int ia, ib;
    @(negedge clk);
    t_rst = r; t_start = s; t_abort = ab; t_valid = v; t_data = d;
    t_cre = cre; t_cwe = cwe; t_caddr = ca; t_cdo = cdo;
    #1;
    check_side("A", c_BASE_A, a_cpu_rst, a_ready, a_done, a_we, a_re, a_addr, a_do, a_cdi, ref_a[t_caddr]);
    check_side("B", c_BASE_B, b_cpu_rst, b_ready, b_done, b_we, b_re, b_addr, b_do, b_cdi, ref_b[t_caddr]);
    if (r) begin
      m_load = 0; m_rel = 0; m_run = 0; m_cnt = 0;
    end else if (m_load) begin
      if (ab) begin
        m_load = 0; m_cnt = 0;
      end else if (v) begin
        ia = (int'(c_BASE_A) + m_cnt) % 32768;
        ib = (int'(c_BASE_B) + m_cnt) % 32768;
        ref_a[ia] = d;
        ref_b[ib] = d;
        m_cnt++;
        if (m_cnt == c_LEN) begin
          m_load = 0; m_rel = 1; m_cnt = 0;
        end
      end
    end else if (m_rel) begin
      m_rel = 0;
      if (s) m_load = 1; else m_run = 1;
    end else if (m_run) begin
      if (cwe) begin
        ref_a[ca] = cdo;
        ref_b[ca] = cdo;
      end
      if (s) begin
        m_run = 0; m_load = 1; m_cnt = 0;
      end
    end else if (s) begin
      m_load = 1; m_cnt = 0;
    end
  endtask

  // shorthand for loader-side cycles with the core idle
  task automatic ld(input logic s, input logic ab, input logic v, input logic [7:0] d);
    step(1'b0, s, ab, v, d, 1'b0, 1'b0, 15'd0, 8'd0);
  endtask

  initial begin
    logic [14:0] ca;
    logic [7:0]  vpat;
    for (int i = 0; i < 32768; i++) begin
      mem_a[i] = 8'h00; mem_b[i] = 8'h00; ref_a[i] = 8'h00; ref_b[i] = 8'h00;
    end
    mem_a[5] = 8'hAA; mem_b[5] = 8'hAA; ref_a[5] = 8'hAA; ref_b[5] = 8'hAA;
    m_load = 0; m_rel = 0; m_run = 0; m_cnt = 0;
    t_rst = 1; t_start = 0; t_abort = 0; t_valid = 0; t_data = 0;
    t_cre = 0; t_cwe = 0; t_caddr = 0; t_cdo = 0;

    // reset, with start/abort/handshake attempts that must be overridden
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 15'd0, 8'd0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'h55, 1'b1, 1'b1, 15'd3, 8'h11);

    // straight four-byte load, release, run
    ld(1'b1, 1'b0, 1'b0, 8'h00);
    ld(1'b0, 1'b0, 1'b1, 8'h4E);
    ld(1'b1, 1'b0, 1'b1, 8'h40);
    ld(1'b0, 1'b0, 1'b1, 8'hAA);
    ld(1'b1, 1'b0, 1'b1, 8'hAA);   // final byte; start is ignored here
    ld(1'b0, 1'b1, 1'b0, 8'h00);   // release; abort has no effect
    // core read of preloaded address 5, then a write of 3C to address 7
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 15'd5, 8'h00);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 15'd7, 8'h3C);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 15'd7, 8'h00);

    // reload from RUN with a core request in the same cycle, then a gappy stream
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 15'd9, 8'h77);
    vpat = 8'b1011_001;
    for (int i = 6; i >= 0; i--) ld(1'b0, 1'b0, vpat[i], 8'($urandom));
    ld(1'b0, 1'b0, 1'b0, 8'h00);   // release
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 15'd2, 8'h00);

    // abort together with the third handshake, then a clean restart
    ld(1'b1, 1'b0, 1'b0, 8'h00);
    ld(1'b0, 1'b0, 1'b1, 8'h01);
    ld(1'b0, 1'b0, 1'b1, 8'h02);
    ld(1'b0, 1'b1, 1'b1, 8'h03);
    ld(1'b0, 1'b0, 1'b1, 8'h04);   // back in HOLD: nothing written
    ld(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) ld(1'b0, 1'b0, 1'b1, 8'(8'hC0 + i));
    ld(1'b0, 1'b0, 1'b0, 8'h00);

    // reset mid-load after two bytes, with a valid byte offered during reset
    ld(1'b1, 1'b0, 1'b0, 8'h00);
    ld(1'b0, 1'b0, 1'b1, 8'hD1);
    ld(1'b0, 1'b0, 1'b1, 8'hD2);
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'hD3, 1'b0, 1'b0, 15'd0, 8'd0);
    ld(1'b0, 1'b0, 1'b1, 8'hD4);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      ca = ($urandom_range(0, 1) == 0) ? 15'($urandom_range(0, 9))
                                        : 15'(15'h7FFA + 15'($urandom_range(0, 5)));
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
           8'($urandom), 1'($urandom), 1'($urandom), ca, 8'($urandom));
    end

    // memory contents near both load windows
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      check_val("mem A low", 32'(mem_a[i]), 32'(ref_a[i]));
      check_val("mem B low", 32'(mem_b[i]), 32'(ref_b[i]));
      check_val("mem A high", 32'(mem_a[32752 + i]), 32'(ref_a[32752 + i]));
      check_val("mem B high", 32'(mem_b[32752 + i]), 32'(ref_b[32752 + i]));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
